// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for memory_unit: round-robin with optional lock and busy timeout.
// Issue-to-ack latency 4 cycles + memory busy time; requesters hold req until their one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  lock_a,
  input  logic                  lock_b,
  input  logic [1:0]            func_a,
  input  logic [1:0]            func_b,
  input  logic [ADDR_WIDTH-1:0] addr1_a,
  input  logic [ADDR_WIDTH-1:0] addr2_a,
  input  logic [ADDR_WIDTH-1:0] addr1_b,
  input  logic [ADDR_WIDTH-1:0] addr2_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  owner,
  output logic [1:0]            mem_func,
  output logic                  mem_execute,
  output logic [ADDR_WIDTH-1:0] mem_address1,
  output logic [ADDR_WIDTH-1:0] mem_address2,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data1,
  input  logic [DATA_WIDTH-1:0] mem_read_data2,
  output logic                  timeout_err
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t        state;
  logic          locked;
  logic          rr_next;
  logic [CW-1:0] cnt;

  logic want_a, want_b, pick_b;

  // While locked, only the current owner may win; the other request is ignored.
  assign want_a = req_a & (~locked | ~owner);
  assign want_b = req_b & (~locked | owner);
  assign pick_b = (want_a & want_b) ? rr_next : want_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mem_func       <= '0;
      mem_execute    <= 1'b0;
      mem_address1   <= '0;
      mem_address2   <= '0;
      mem_write_data <= '0;
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      rdata1         <= '0;
      rdata2         <= '0;
      owner          <= 1'b0;
      timeout_err    <= 1'b0;
      locked         <= 1'b0;
      rr_next        <= 1'b0;
      cnt            <= '0;
    end else begin
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      mem_execute <= 1'b0;
      case (state)
        IDLE: begin
          // A timeout ack lands in IDLE; requests are sampled only after it.
          if (mem_ready && !ack_a && !ack_b && (want_a || want_b)) begin
            owner          <= pick_b;
            mem_execute    <= 1'b1;
            mem_func       <= pick_b ? func_b  : func_a;
            mem_address1   <= pick_b ? addr1_b : addr1_a;
            mem_address2   <= pick_b ? addr2_b : addr2_a;
            mem_write_data <= pick_b ? wdata_b : wdata_a;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (state == WAIT_DONE && mem_ready) begin
            rdata1 <= mem_read_data1;
            rdata2 <= mem_read_data2;
            ack_a  <= ~owner;
            ack_b  <= owner;
            state  <= RESP;
          end else if (cnt == CNT_MAX) begin
            timeout_err    <= 1'b1;
            rdata1         <= '0;
            rdata2         <= '0;
            ack_a          <= ~owner;
            ack_b          <= owner;
            locked         <= 1'b0;
            rr_next        <= ~owner;
            mem_func       <= '0;
            mem_address1   <= '0;
            mem_address2   <= '0;
            mem_write_data <= '0;
            state          <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == WAIT_BUSY && !mem_ready) state <= WAIT_DONE;
          end
        end
        RESP: begin
          locked         <= owner ? lock_b : lock_a;
          rr_next        <= ~owner;
          mem_func       <= '0;
          mem_address1   <= '0;
          mem_address2   <= '0;
          mem_write_data <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level arbitration model feeds a scoreboard,
// a negedge monitor checks every execute and ack; includes a behavioural memory_unit.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int TO = 16;

  typedef struct packed {
    logic          lock;
    logic [1:0]    func;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] wd;
  } txn_t;

  typedef struct packed {
    logic          who;
    logic          to;
    txn_t          t;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
  } exp_t;

  logic clk, rst;
  logic req_a, req_b, lock_a, lock_b;
  logic [1:0] func_a, func_b;
  logic [AW-1:0] addr1_a, addr2_a, addr1_b, addr2_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic ack_a, ack_b, owner, mem_execute, mem_ready, timeout_err;
  logic [DW-1:0] rdata1, rdata2, mem_write_data, mem_read_data1, mem_read_data2;
  logic [1:0] mem_func;
  logic [AW-1:0] mem_address1, mem_address2;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
    .func_a(func_a), .func_b(func_b),
    .addr1_a(addr1_a), .addr2_a(addr2_a), .addr1_b(addr1_b), .addr2_b(addr2_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata1(rdata1), .rdata2(rdata2), .owner(owner),
    .mem_func(mem_func), .mem_execute(mem_execute),
    .mem_address1(mem_address1), .mem_address2(mem_address2),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready),
    .mem_read_data1(mem_read_data1), .mem_read_data2(mem_read_data2),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_exec = 0;
  int cyc = 0;
  int last_exec = 0;
  exp_t exp_exec[$];
  exp_t exp_ack[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected or never seen", nm);
  endtask

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a, input logic [1:0] f, input bit sec);
    return 64'hC0DE_0000_0000_0000 | ({54'd0, a} << 20) | ({62'd0, f} << 8) | (sec ? 64'h5 : 64'hA);
  endfunction

  // Behavioural memory_unit: drops ready the cycle after accepting execute, busy 1..5 cycles.
  logic hang = 1'b0;
  logic nr_force = 1'b0;
  logic m_rdy, m_busy;
  int m_cnt;
  logic [1:0] l_f;
  logic [AW-1:0] l_a1, l_a2;
  assign mem_ready = m_rdy && !nr_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy <= 1'b1; m_busy <= 1'b0; m_cnt <= 0;
      mem_read_data1 <= '0; mem_read_data2 <= '0;
    end else if (!m_busy) begin
      if (mem_execute && mem_ready) begin
        m_busy <= 1'b1; m_rdy <= 1'b0; m_cnt <= $urandom_range(1, 5);
        l_f <= mem_func; l_a1 <= mem_address1; l_a2 <= mem_address2;
        mem_read_data1 <= {$urandom, $urandom};
        mem_read_data2 <= {$urandom, $urandom};
      end
    end else if (!hang) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0; m_rdy <= 1'b1;
        mem_read_data1 <= mdata(l_a1, l_f, 1'b0);
        mem_read_data2 <= mdata(l_a2, l_f, 1'b1);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Transaction-level reference: who is served next, given pending work, lock and fairness.
  logic m_locked = 1'b0, m_owner = 1'b0, m_rr = 1'b0, m_timeout = 1'b0;

  task automatic model_round(input txn_t qa[$], input txn_t qb[$]);
    exp_t e;
    while (qa.size() > 0 || qb.size() > 0) begin
      if (m_locked) e.who = m_owner;
      else if (qa.size() > 0 && qb.size() > 0) e.who = m_rr;
      else e.who = (qa.size() == 0);
      e.t  = e.who ? qb.pop_front() : qa.pop_front();
      e.to = m_timeout;
      e.r1 = m_timeout ? '0 : mdata(e.t.a1, e.t.func, 1'b0);
      e.r2 = m_timeout ? '0 : mdata(e.t.a2, e.t.func, 1'b1);
      exp_exec.push_back(e);
      exp_ack.push_back(e);
      m_locked = m_timeout ? 1'b0 : e.t.lock;
      m_owner  = e.who;
      m_rr     = ~e.who;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (mem_execute) begin
        n_exec++;
        last_exec = cyc;
        if (exp_exec.size() == 0) fail_now("exec_unexpected");
        else begin
          e = exp_exec.pop_front();
          chk("exec_owner", 64'(owner), 64'(e.who));
          chk("exec_func", 64'(mem_func), 64'(e.t.func));
          chk("exec_addr1", 64'(mem_address1), 64'(e.t.a1));
          chk("exec_addr2", 64'(mem_address2), 64'(e.t.a2));
          chk("exec_wdata", mem_write_data, e.t.wd);
        end
      end
      if (ack_a || ack_b) begin
        chk("ack_exclusive", 64'(ack_a && ack_b), 64'd0);
        if (exp_ack.size() == 0) fail_now("ack_unexpected");
        else begin
          e = exp_ack.pop_front();
          chk("ack_who", 64'(ack_b), 64'(e.who));
          chk("ack_owner", 64'(owner), 64'(e.who));
          chk("ack_rdata1", rdata1, e.r1);
          chk("ack_rdata2", rdata2, e.r2);
          if (e.to) begin
            chk("timeout_latency", 64'(cyc - last_exec), 64'd17);
            chk("timeout_err_set", 64'(timeout_err), 64'd1);
          end
        end
      end
    end
  end

  task automatic set_req(input bit who, input logic r, input txn_t t);
    if (!who) begin
      req_a = r; lock_a = t.lock; func_a = t.func; addr1_a = t.a1; addr2_a = t.a2; wdata_a = t.wd;
    end else begin
      req_b = r; lock_b = t.lock; func_b = t.func; addr1_b = t.a1; addr2_b = t.a2; wdata_b = t.wd;
    end
  endtask

  // Holds req across back-to-back transactions; payload changes only after the ack cycle.
  task automatic drive(input bit who, input txn_t q[$]);
    int c;
    for (int i = 0; i < q.size(); i++) begin
      set_req(who, 1'b1, q[i]);
      c = 0;
      do begin @(negedge clk); c++; end while (!(who ? ack_b : ack_a) && c < 300);
      if (c >= 300) begin fail_now(who ? "ack_b_wait" : "ack_a_wait"); break; end
      @(posedge clk); #1;
    end
    set_req(who, 1'b0, '0);
  endtask

  task automatic run_round(input txn_t qa[$], input txn_t qb[$]);
    model_round(qa, qb);
    @(posedge clk); #1;
    fork
      begin if (qa.size() > 0) drive(1'b0, qa); end
      begin if (qb.size() > 0) drive(1'b1, qb); end
    join
    repeat (2) @(posedge clk);
  endtask

  function automatic txn_t rnd_txn(input logic lk);
    txn_t t;
    t.lock = lk;
    t.func = 2'($urandom_range(0, 3));
    t.a1 = AW'($urandom);
    t.a2 = AW'($urandom);
    t.wd = {$urandom, $urandom};
    return t;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_func"}, 64'(mem_func), 64'd0);
    chk({pfx, "_mem_execute"}, 64'(mem_execute), 64'd0);
    chk({pfx, "_mem_address1"}, 64'(mem_address1), 64'd0);
    chk({pfx, "_mem_address2"}, 64'(mem_address2), 64'd0);
    chk({pfx, "_mem_write_data"}, mem_write_data, 64'd0);
    chk({pfx, "_acks"}, 64'({ack_a, ack_b}), 64'd0);
    chk({pfx, "_rdata1"}, rdata1, 64'd0);
    chk({pfx, "_rdata2"}, rdata2, 64'd0);
    chk({pfx, "_owner"}, 64'(owner), 64'd0);
    chk({pfx, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    txn_t qa[$], qb[$], t;
    int na, nb, e0, c;
    rst = 1'b1;
    set_req(1'b0, 1'b0, '0);
    set_req(1'b1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Contention from reset: expect A,B,A,B
    qa = {rnd_txn(1'b0), rnd_txn(1'b0)};
    qb = {rnd_txn(1'b0), rnd_txn(1'b0)};
    run_round(qa, qb);

    // Single A read
    t = '0; t.func = 2'd1; t.a1 = 10'd5;
    qa = {t}; qb = {};
    run_round(qa, qb);

    // Not ready in IDLE: no execute until mem_ready returns
    qa = {rnd_txn(1'b0)};
    nr_force = 1'b1;
    model_round(qa, qb);
    @(posedge clk); #1;
    e0 = n_exec;
    fork
      drive(1'b0, qa);
      begin
        repeat (6) @(negedge clk);
        chk("no_exec_not_ready", 64'(n_exec), 64'(e0));
        nr_force = 1'b0;
      end
    join
    repeat (2) @(posedge clk);

    // Lock: B holds the bus for three transactions while A waits
    qa = {rnd_txn(1'b0)};
    qb = {rnd_txn(1'b1), rnd_txn(1'b1), rnd_txn(1'b0)};
    run_round(qa, qb);

    for (int r = 0; r < 25; r++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na == 0 && nb == 0) na = 1;
      qa = {}; qb = {};
      for (int i = 0; i < na; i++) qa.push_back(rnd_txn((i < na - 1) ? 1'($urandom_range(0, 1)) : 1'b0));
      for (int i = 0; i < nb; i++) qb.push_back(rnd_txn((i < nb - 1) ? 1'($urandom_range(0, 1)) : 1'b0));
      run_round(qa, qb);
    end

    // Timeout: memory never completes
    hang = 1'b1; m_timeout = 1'b1;
    qa = {rnd_txn(1'b0)}; qb = {};
    run_round(qa, qb);
    hang = 1'b0; m_timeout = 1'b0;
    c = 0;
    while (!mem_ready && c < 50) begin @(posedge clk); c++; end
    if (c >= 50) fail_now("mem_ready_recover");
    chk("timeout_err_sticky1", 64'(timeout_err), 64'd1);
    qa = {rnd_txn(1'b0)}; qb = {rnd_txn(1'b0)};
    run_round(qa, qb);
    chk("timeout_err_sticky2", 64'(timeout_err), 64'd1);

    // Reset while waiting for completion
    hang = 1'b1;
    qa = {}; qb = {rnd_txn(1'b0)};
    model_round(qa, qb);
    @(posedge clk); #1;
    e0 = n_exec;
    set_req(1'b1, 1'b1, qb[0]);
    c = 0;
    while (n_exec == e0 && c < 20) begin @(negedge clk); c++; end
    if (c >= 20) fail_now("reset_test_exec");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midreset");
    set_req(1'b1, 1'b0, '0);
    exp_exec = {}; exp_ack = {};
    m_locked = 1'b0; m_owner = 1'b0; m_rr = 1'b0;
    hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    qa = {}; qb = {rnd_txn(1'b0)};
    run_round(qa, qb);

    repeat (5) @(posedge clk);
    chk("exec_queue_drained", 64'(exp_exec.size()), 64'd0);
    chk("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of memory_unit. Replaces the combinational memory_mux.
- Requester A is the traversal unit (MTU); requester B is the Nock execution module (NEM).
- Accepts one memory transaction at a time via req/ack handshake, issues it to memory_unit, waits for completion, returns latched read data.
- Round-robin fairness, optional bus lock for multi-transaction sequences, busy-timeout error.

Parameters:
- ADDR_WIDTH, 10, address width; set to `memory_addr_width at instantiation.
- DATA_WIDTH, 64, data width; set to `memory_data_width at instantiation.
- TIMEOUT, 1024, max cycles from issue to memory completion before error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_a / req_b  in  1  transaction request; held high with payload stable until ack
- lock_a / lock_b  in  1  keep ownership after this transaction
- func_a / func_b  in  2  memory function code
- addr1_a, addr2_a / addr1_b, addr2_b  in  ADDR_WIDTH  operand addresses
- wdata_a / wdata_b  in  DATA_WIDTH  write data
- ack_a / ack_b  out  1  one-cycle pulse: transaction complete, rdata valid this cycle
- rdata1, rdata2  out  DATA_WIDTH  latched read data (shared)
- owner  out  1  0=A, 1=B: current/last grant
- mem_func  out  2  to memory_unit func
- mem_execute  out  1  to memory_unit execute
- mem_address1, mem_address2  out  ADDR_WIDTH  to memory_unit
- mem_write_data  out  DATA_WIDTH  to memory_unit
- mem_ready  in  1  memory_unit is_ready
- mem_read_data1, mem_read_data2  in  DATA_WIDTH  memory_unit read data
- timeout_err  out  1  sticky; set on timeout

Behaviour:
- Reset values, applied asynchronously:
  - state=IDLE; all mem_* outputs 0; ack_a=ack_b=0; rdata1=rdata2=0; owner=0; timeout_err=0; locked=0; rr_next=A.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Acts only when mem_ready=1 and at least one req is high.
  - If locked=1, only the owner may be granted; the other req is ignored.
  - Otherwise, if one req is high, grant it. If both are high, grant rr_next.
  - On grant: set owner, capture that requester's func/addr1/addr2/wdata into mem_* registers, go to ISSUE.
- ISSUE: mem_execute=1 for exactly one cycle; counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_ready=0; memory_unit drops is_ready the cycle after accepting execute. Then go to WAIT_DONE.
- WAIT_DONE: wait for mem_ready=1; then latch mem_read_data1/2 into rdata1/2 and go to RESP.
- RESP:
  - Pulse ack of owner for one cycle.
  - locked <= lock_<owner> sampled this cycle.
  - rr_next <= ~owner.
  - Return to IDLE.
- Latency from req to ack with an idle, ready memory: 4 cycles plus memory busy time.
- mem_address/func/write_data stay stable from ISSUE through RESP; they return to 0 in IDLE.
- Counter:
  - Counts each cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT-1, set timeout_err, pulse ack of owner with rdata=0, clear locked, go to IDLE.
  - Saturates; no wrap.
- Requester holding req after ack is treated as a new request. A back-to-back lock owner is regranted in IDLE without arbitration.
- Deasserting req mid-transaction has no effect; the transaction completes and ack is still pulsed.
- Simultaneous req_a/req_b with no lock: alternate strictly (A,B,A,B...) starting with A after reset.
- ack_a and ack_b are never high together; mem_execute is never high outside ISSUE.
- Reset mid-transaction aborts immediately to reset values; no ack is issued.

Test Plan:
- Single A read:
  - Stimulus: req_a=1, func_a=1, addr1_a=5, memory returns 0xABCD after 3 busy cycles.
  - Required: one mem_execute pulse with mem_address1=5; ack_a one cycle with rdata1=0xABCD; owner=0.
- Contention:
  - Stimulus: req_a and req_b held high for 4 transactions.
  - Required: grant order A,B,A,B; never two acks in the same cycle.
- Lock:
  - Stimulus: B issues 3 transactions with lock_b=1 while req_a stays high; lock_b=0 on the third.
  - Required: B,B,B, then A granted.
- Timeout:
  - Stimulus: TIMEOUT=16, mem_ready held 0 after execute.
  - Required: ack on cycle 16 of wait, rdata=0, timeout_err=1 and stays set.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT_DONE.
  - Required: all outputs 0 asynchronously; no ack; next req_b after reset granted normally.
- Not ready:
  - Stimulus: req_a while mem_ready=0 in IDLE.
  - Required: no mem_execute until mem_ready=1.
